// File: rtl/pipeline_mem.sv
// MEM stage: data-memory access over req/gnt/rvalid, load alignment and
// sign/zero extension, write-back select, stall generation, MEM/WB register.
// Ports: clk/resetn (sync, active-low); *_e_i from EXE; dmem_* data bus;
// stall_m_o freezes IF/ID/EXE; *_m_o registered MEM/WB outputs;
// bypass_m_o is the combinational forward value of the op in MEM.
module pipeline_mem #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush_m_i,
  input  logic [XLEN-1:0]   alu_result_e_i,
  input  logic [3:0]        dmem_type_e_i,
  input  logic [XLEN-1:0]   rs2_e_i,
  input  logic [XLEN-1:0]   extended_imm_e_i,
  input  logic [XLEN-1:0]   pc_plus4_e_i,
  input  logic              reg_write_en_e_i,
  input  logic [4:0]        rd_idx_e_i,
  input  logic [3:0]        result_src_e_i,
  input  logic              instr_illegal_e_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              stall_m_o,
  output logic [XLEN-1:0]   wb_data_m_o,
  output logic              reg_write_en_m_o,
  output logic [4:0]        rd_idx_m_o,
  output logic              instr_illegal_m_o,
  output logic              ld_misalign_m_o,
  output logic              st_misalign_m_o,
  output logic [XLEN-1:0]   bypass_m_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t state;

  logic ld, st, sz_b, sz_h, sz_w, sgn;

  always_comb begin
    ld   = 1'b0;
    st   = 1'b0;
    sz_b = 1'b0;
    sz_h = 1'b0;
    sz_w = 1'b0;
    sgn  = 1'b0;
    case (dmem_type_e_i)
      4'b0001: begin ld = 1'b1; sz_b = 1'b1; sgn = 1'b1; end
      4'b0010: begin ld = 1'b1; sz_h = 1'b1; sgn = 1'b1; end
      4'b0011: begin ld = 1'b1; sz_w = 1'b1; end
      4'b0100: begin ld = 1'b1; sz_b = 1'b1; end
      4'b0101: begin ld = 1'b1; sz_h = 1'b1; end
      4'b1000: begin st = 1'b1; sz_b = 1'b1; end
      4'b1001: begin st = 1'b1; sz_h = 1'b1; end
      4'b1010: begin st = 1'b1; sz_w = 1'b1; end
      default: ;
    endcase
  end

  logic [1:0] off;
  logic       mis;
  logic       issue;

  assign off   = alu_result_e_i[1:0];
  assign mis   = (sz_h & off[0]) | (sz_w & (|off));
  assign issue = (state == IDLE) & (ld | st)
               & ~mis & ~flush_m_i;

  logic [3:0]        be_in;
  logic [XLEN-1:0]   wdata_in;
  logic [XLEN-1:0]   sel_in;
  logic [ADDR_W-1:0] addr_in;

  always_comb begin
    be_in    = 4'b0000;
    wdata_in = '0;
    if (sz_b) be_in = 4'b0001 << off;
    if (sz_h) be_in = 4'b0011 << off;
    if (sz_w) be_in = 4'b1111;
    if (st) begin
      if (sz_b) wdata_in = {(XLEN/8){rs2_e_i[7:0]}};
      if (sz_h) wdata_in = {(XLEN/16){rs2_e_i[15:0]}};
      if (sz_w) wdata_in = rs2_e_i;
    end
  end

  // Non-memory part of the one-hot write-back select.
  assign sel_in = (result_src_e_i[0] ? alu_result_e_i   : '0)
                | (result_src_e_i[1] ? extended_imm_e_i : '0)
                | (result_src_e_i[3] ? pc_plus4_e_i     : '0);

  assign addr_in = {alu_result_e_i[ADDR_W-1:2], 2'b00};

  // Everything the access needs is captured at issue, so the
  // upstream inputs (held or not) and late flushes are irrelevant.
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   sel_q;
  logic              we_q, ld_q, b_q, h_q, sgn_q;
  logic              src2_q, rwe_q, ill_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;

  function automatic logic [XLEN-1:0] ext(
    input logic [XLEN-1:0] d,
    input logic [1:0]      o,
    input logic            b,
    input logic            h,
    input logic            s
  );
    logic [7:0]  b8;
    logic [15:0] h16;
    b8  = d[{o, 3'b000} +: 8];
    h16 = d[{o[1], 4'b0000} +: 16];
    if (b)
      ext = {{(XLEN-8){s & b8[7]}}, b8};
    else if (h)
      ext = {{(XLEN-16){s & h16[15]}}, h16};
    else
      ext = d;
  endfunction

  logic [XLEN-1:0] ld_data;
  logic            done;

  assign ld_data = ext(dmem_rdata_i, off_q, b_q, h_q, sgn_q);
  assign done    = (state == RESP) & dmem_rvalid_i;

  assign stall_m_o = issue | (state == REQ)
                   | ((state == RESP) & ~dmem_rvalid_i);

  assign dmem_req_o   = issue | (state == REQ);
  assign dmem_addr_o  = (state == IDLE) ? addr_in  : addr_q;
  assign dmem_be_o    = (state == IDLE) ? be_in    : be_q;
  assign dmem_wdata_o = (state == IDLE) ? wdata_in : wdata_q;
  assign dmem_we_o    = (state == IDLE) ? st       : we_q;

  always_comb begin
    bypass_m_o = '0;
    if (state == IDLE) begin
      if (!ld) bypass_m_o = sel_in;
    end else if (ld_q) begin
      if (done) bypass_m_o = ld_data;
    end else begin
      bypass_m_o = sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      b_q     <= 1'b0;
      h_q     <= 1'b0;
      sgn_q   <= 1'b0;
      src2_q  <= 1'b0;
      rwe_q   <= 1'b0;
      ill_q   <= 1'b0;
      off_q   <= '0;
      rd_q    <= '0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          state   <= dmem_gnt_i ? RESP : REQ;
          addr_q  <= addr_in;
          be_q    <= be_in;
          wdata_q <= wdata_in;
          sel_q   <= sel_in;
          we_q    <= st;
          ld_q    <= ld;
          b_q     <= sz_b;
          h_q     <= sz_h;
          sgn_q   <= sgn;
          src2_q  <= result_src_e_i[2];
          rwe_q   <= reg_write_en_e_i;
          ill_q   <= instr_illegal_e_i;
          off_q   <= off;
          rd_q    <= rd_idx_e_i;
        end
        REQ:  if (dmem_gnt_i) state <= RESP;
        RESP: if (dmem_rvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || stall_m_o) begin
      wb_data_m_o       <= '0;
      reg_write_en_m_o  <= 1'b0;
      rd_idx_m_o        <= '0;
      instr_illegal_m_o <= 1'b0;
      ld_misalign_m_o   <= 1'b0;
      st_misalign_m_o   <= 1'b0;
    end else if (done) begin
      wb_data_m_o       <= sel_q | (src2_q ? ld_data : '0);
      reg_write_en_m_o  <= rwe_q;
      rd_idx_m_o        <= rd_q;
      instr_illegal_m_o <= ill_q;
      ld_misalign_m_o   <= 1'b0;
      st_misalign_m_o   <= 1'b0;
    end else if (flush_m_i) begin
      wb_data_m_o       <= '0;
      reg_write_en_m_o  <= 1'b0;
      rd_idx_m_o        <= '0;
      instr_illegal_m_o <= 1'b0;
      ld_misalign_m_o   <= 1'b0;
      st_misalign_m_o   <= 1'b0;
    end else begin
      wb_data_m_o       <= sel_in;
      reg_write_en_m_o  <= reg_write_en_e_i & ~mis;
      rd_idx_m_o        <= rd_idx_e_i;
      instr_illegal_m_o <= instr_illegal_e_i;
      ld_misalign_m_o   <= ld & mis;
      st_misalign_m_o   <= st & mis;
    end
  end

endmodule

// File: doc/pipeline_mem.md
Name: pipeline_mem

Overview:
- 5-stage pipeline MEM stage, directly downstream of the EXE stage.
- Takes the EXE result, load/store type and store data, and runs the data-memory access over a req/gnt/rvalid bus.
- Aligns, sign- or zero-extends load data and selects the write-back value.
- Holds the pipeline with a stall while an access is outstanding; registers results into the MEM/WB boundary.

Parameters:
- ADDR_W, 32, data bus address width.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- flush_m_i  in  1  squash the instruction entering MEM
- alu_result_e_i  in  32  effective address or ALU result
- dmem_type_e_i  in  4  access type: 0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; other codes = none
- rs2_e_i  in  32  store data
- extended_imm_e_i  in  32  lui value
- pc_plus4_e_i  in  32  jal/jalr link value
- reg_write_en_e_i  in  1  RF write enable
- rd_idx_e_i  in  5  destination register index
- result_src_e_i  in  4  one-hot: [0] alu, [1] imm, [2] mem, [3] pc+4
- instr_illegal_e_i  in  1  illegal instruction flag
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  response valid (loads and stores)
- dmem_rdata_i  in  32  load data word
- stall_m_o  out  1  freeze IF/ID/EXE
- wb_data_m_o  out  32  registered write-back value
- reg_write_en_m_o  out  1  registered
- rd_idx_m_o  out  5  registered
- instr_illegal_m_o  out  1  registered
- ld_misalign_m_o  out  1  registered load-misaligned exception
- st_misalign_m_o  out  1  registered store-misaligned exception
- bypass_m_o  out  32  combinational forward value of the instruction currently in MEM

Behaviour:
- Reset: resetn synchronous, active-low, clock clk. On reset, all registered outputs = 0, FSM = IDLE, dmem_req_o = 0, stall_m_o = 0.
- Misalignment:
  - Halfword with addr[0] = 1 is misaligned; word with addr[1:0] != 0 is misaligned.
  - A misaligned access never issues dmem_req_o.
  - It sets ld_misalign_m_o or st_misalign_m_o and forces reg_write_en_m_o = 0 in the MEM/WB register.
- Byte enables:
  - SB/LB/LBU: 0001 << addr[1:0].
  - SH/LH/LHU: 0011 << addr[1:0].
  - SW/LW: 1111.
- Store data: SB replicates rs2[7:0] x4; SH replicates rs2[15:0] x2; SW passes rs2 unchanged.
- FSM states: IDLE, REQ, RESP.
  - IDLE: an aligned memory op that is not flushed drives dmem_req_o = 1 combinationally. If dmem_gnt_i is high in the same cycle go to RESP, else go to REQ.
  - REQ: hold dmem_req_o and the address, be, wdata and we registered from entry. Go to RESP on gnt.
  - RESP: dmem_req_o = 0. On dmem_rvalid_i, capture the result and return to IDLE.
  - rvalid in the same cycle as gnt is not permitted (minimum 1-cycle response). Latency for gnt = 1 cycle and rvalid next cycle is 2 cycles.
- Stall: stall_m_o = 1 while a memory op sits in MEM and the FSM has not yet seen rvalid for it.
  - Covers: IDLE with a new op, REQ, and RESP without rvalid.
  - stall_m_o = 0 in the rvalid cycle.
  - While stalled, the EXE-side inputs are held by the upstream stages.
  - The in-flight request parameters are registered at issue, so held or changed inputs do not matter.
- Load extension, from the byte or half selected by addr[1:0]: LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
- wb_data selection (one-hot OR):
  - alu_result when src[0]
  - imm when src[1]
  - extended load when src[2]
  - pc_plus4 when src[3]
- MEM/WB register:
  - Loads when stall_m_o = 0.
  - While stalled, loads a bubble: reg_write_en = 0, rd = 0, exceptions = 0. wb_data is don't-care but must be 0.
  - flush_m_i with no outstanding access: the register loads a bubble and no request is issued.
  - flush_m_i during REQ/RESP is ignored; the access completes, because the bus cannot be cancelled.
- bypass_m_o: selected value for non-load ops; for loads, the extended dmem_rdata_i when rvalid, else 0.
- Reset mid-access: FSM returns to IDLE. Any late rvalid after reset is ignored, because the FSM is not in RESP.

Test Plan:
- ADD result 0x1234, src=0001, rd=5 -> next cycle wb_data_m_o=0x1234, rd_idx_m_o=5, reg_write_en_m_o=1, no dmem_req_o.
- SB addr 0x1003, rs2=0xAB, gnt same cycle, rvalid next -> be=1000, wdata=0xABABABAB, addr=0x1000, stall for 1 cycle.
- LB addr 0x2002, rdata 0x00800000, gnt delayed 3 cycles -> stall held for 3 cycles in REQ, then wb_data=0xFFFFFF80; LBU at the same address gives 0x00000080.
- LW addr 0x3002 -> no request, ld_misalign_m_o=1, reg_write_en_m_o=0; SH addr 0x3001 -> st_misalign_m_o=1.
- flush_m_i with a pending LW in IDLE -> no request, bubble written; flush asserted in RESP -> access completes, no second request.
- resetn low while in RESP, then rvalid pulse -> outputs 0, FSM IDLE, rvalid ignored.
